// File: rtl/boot_mem_arbiter_pkg.sv
// Shared types and constants for the boot ROM arbiter and its round-robin helper.
package boot_mem_arb_pkg;

   typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_t;

   typedef struct packed {
      logic        valid;
      port_t       port;
      logic        err;
      logic [31:0] rdata;
   } arb_resp_t;

   localparam int unsigned DEFAULT_MEM_WORDS = 4096;
   localparam logic [31:0] BOOT_REGION_BYTES = 32'(DEFAULT_MEM_WORDS * 4);

   // Unsigned offset compare also rejects addresses below the base (they wrap high).
   function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] bytes);
      return (addr - base) < bytes;
   endfunction

endpackage

// File: rtl/boot_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is PORT_INSTR, req[1]/gnt[1] is PORT_DATA.
// last_served is exposed for observation only.
module rr_arb2
   import boot_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       last_served
);

   port_t last_q;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_DATA;
      end else if (advance && (gnt != 2'b00)) begin
         last_q <= gnt[1] ? PORT_DATA : PORT_INSTR;
      end
   end

   assign last_served = last_q;

endmodule

// File: rtl/boot_mem_arbiter.sv
// Shares the combinational boot ROM between instruction fetch and data ports.
// Optional BOOT_MEM_ARB_ERR_EN: flag data writes / out-of-range data accesses on data_err.
module boot_mem_arbiter
   import boot_mem_arb_pkg::*;
#(
   parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic        instr_rvalid,
   output logic [31:0] instr_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata
);

   // Handshake: gnt is combinational in the cycle a req is accepted; the matching
   // rvalid is high for exactly one cycle on the next cycle, with no backpressure.
   localparam logic [31:0] REGION_BYTES = 32'(MEM_WORDS * 4);

   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        last_served_unused;
   logic [31:0] last_addr;
   logic        out_of_range;
   logic        is_write;
   logic        err_now;
   logic        wr_bus_unused;
   arb_resp_t   resp;

   // Grants are suppressed while reset is asserted so every output reads 0.
   assign req = {data_req & rst_n, instr_req & rst_n};

   rr_arb2 u_rr_arb2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .advance     (1'b1),
      .gnt         (gnt),
      .last_served (last_served_unused)
   );

   assign instr_gnt = gnt[0];
   assign data_gnt  = gnt[1];

   always_comb begin
      mem_addr = last_addr;
      if (gnt[0])      mem_addr = instr_addr;
      else if (gnt[1]) mem_addr = data_addr;
   end

   assign out_of_range  = !in_region(mem_addr, BASE_ADDR, REGION_BYTES);
   assign is_write      = gnt[1] & data_we;
   assign wr_bus_unused = ^{data_be, data_wdata};

`ifdef BOOT_MEM_ARB_ERR_EN
   assign err_now = gnt[1] & (is_write | out_of_range);
`else
   assign err_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_addr <= '0;
         resp      <= '0;
      end else begin
         resp.valid <= |gnt;
         if (|gnt) begin
            last_addr  <= mem_addr;
            resp.port  <= gnt[1] ? PORT_DATA : PORT_INSTR;
            resp.err   <= err_now;
            resp.rdata <= (is_write | out_of_range) ? 32'h0 : mem_rdata;
         end
      end
   end

   assign instr_rvalid = resp.valid & (resp.port == PORT_INSTR);
   assign data_rvalid  = resp.valid & (resp.port == PORT_DATA);
   assign instr_rdata  = resp.rdata;
   assign data_rdata   = resp.rdata;
   assign data_err     = resp.valid & resp.err;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// Bench for boot_mem_arbiter: directed scenarios plus random traffic against a
// behavioural model of the round-robin and response rules.
module tb_boot_mem_arbiter;

   localparam int unsigned MEM_WORDS = 4096;
   localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
`ifdef BOOT_MEM_ARB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
   logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0;
   logic [3:0]  data_be = '0;
   logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err;
   logic [31:0] instr_rdata, data_rdata, mem_addr, mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   // model state: 0 = instr, 1 = data
   int          m_last;
   logic [31:0] m_addr, m_rdata;
   logic [31:0] exp_q[$];
   int          port_q[$];
   bit          err_q[$];

   // per-cycle observed / expected values
   logic [4:0]  obs_ctl, exp_ctl;
   logic [31:0] obs_ma, exp_ma, obs_rdi, obs_rdd, exp_rd;

   always #5 clk = ~clk;

   assign mem_rdata = {16'hB007, mem_addr[15:0]};

   boot_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
      .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
      .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .data_err(data_err),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   task automatic model_reset();
      m_last = 1; m_addr = '0; m_rdata = '0;
      exp_q.delete(); port_q.delete(); err_q.delete();
   endtask

   // Drives one cycle, samples gnt/mem_addr mid-cycle and responses just after the edge.
   task automatic apply(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                        input logic [31:0] da);
      int win;
      logic [31:0] a;
      bit oor, wr, gi, gd, rvi, rvd, er;
      instr_req = ir; instr_addr = ia; data_req = dr; data_we = dwe; data_addr = da;
      data_wdata = $urandom; data_be = 4'($urandom_range(0, 15));
      #2;
      obs_ma = mem_addr;
      gi = instr_gnt; gd = data_gnt;
      if (ir && dr)  win = (m_last == 1) ? 0 : 1;
      else if (ir)   win = 0;
      else if (dr)   win = 1;
      else           win = -1;
      if (win >= 0) begin
         a = (win == 0) ? ia : da;
         m_addr = a; m_last = win;
         oor = (a - BASE_ADDR) >= MEM_WORDS * 4;
         wr = (win == 1) && dwe;
         exp_q.push_back((oor || wr) ? 32'h0 : {16'hB007, a[15:0]});
         port_q.push_back(win);
         err_q.push_back(ERR_EN && (win == 1) && (oor || wr));
      end
      exp_ma = m_addr;
      @(posedge clk); #1;
      rvi = instr_rvalid; rvd = data_rvalid; er = data_err;
      obs_rdi = instr_rdata; obs_rdd = data_rdata;
      obs_ctl = {gi, gd, rvi, rvd, er};
      if (exp_q.size() > 0) begin
         exp_rd = exp_q.pop_front();
         m_rdata = exp_rd;
         win = port_q.pop_front();
         exp_ctl = {win == 0 ? 1'b1 : 1'b0, win == 1 ? 1'b1 : 1'b0, 3'b000};
         exp_ctl[2] = (win == 0); exp_ctl[1] = (win == 1); exp_ctl[0] = err_q.pop_front();
      end else begin
         exp_rd = m_rdata;
         exp_ctl = '0;
      end
      // grant bits come from this cycle's arbitration, not the popped response
      exp_ctl[4] = (m_addr == a) && (ir || dr) && ((ir && !dr) || (ir && dr && m_last == 0));
      exp_ctl[3] = (ir || dr) && (m_last == 1) && dr;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr_req = 1'b1; data_req = 1'b1;
      instr_addr = 32'h0; data_addr = 32'h100;
      repeat (3) @(posedge clk);
      #3;
      vectors++;
      if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, data_err} !== 5'b0 ||
          instr_rdata !== 32'h0 || data_rdata !== 32'h0 || mem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ctl=%b ird=%h drd=%h ma=%h want all zero",
                  {instr_gnt, data_gnt, instr_rvalid, data_rvalid, data_err},
                  instr_rdata, data_rdata, mem_addr);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         apply(i < 1, 32'h0, i < 1, 1'b0, 32'h100);
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL reset_first ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_ma !== exp_ma) begin miscompares++; $display("FAIL reset_first mem_addr c%0d: got %h want %h", i, obs_ma, exp_ma); end
         vectors++; if (obs_rdi !== exp_rd) begin miscompares++; $display("FAIL reset_first instr_rdata c%0d: got %h want %h", i, obs_rdi, exp_rd); end
      end
      // fixed expectation independent of the model: first conflict goes to instr at addr 0
      vectors++; if (m_rdata !== 32'hB007_0000 || obs_rdi !== 32'hB007_0000) begin miscompares++; $display("FAIL reset_first_data: got %h want b0070000", obs_rdi); end
   endtask

   task automatic test_fair_alternation();
      for (int i = 0; i < 7; i++) begin
         apply(i < 6, 32'h10, i < 6, 1'b0, 32'h20);
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL fair ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_ma !== exp_ma) begin miscompares++; $display("FAIL fair mem_addr c%0d: got %h want %h", i, obs_ma, exp_ma); end
         vectors++; if (obs_rdi !== exp_rd || obs_rdd !== exp_rd) begin miscompares++; $display("FAIL fair rdata c%0d: got %h/%h want %h", i, obs_rdi, obs_rdd, exp_rd); end
      end
   endtask

   task automatic test_single_stream();
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 32'h0, i < 4, 1'b0, 32'(i * 4));
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL stream ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_ma !== exp_ma) begin miscompares++; $display("FAIL stream mem_addr c%0d: got %h want %h", i, obs_ma, exp_ma); end
         vectors++; if (obs_rdd !== exp_rd) begin miscompares++; $display("FAIL stream data_rdata c%0d: got %h want %h", i, obs_rdd, exp_rd); end
      end
   endtask

   task automatic test_write_and_oor();
      logic [31:0] addrs [3];
      bit          wes   [3];
      addrs[0] = 32'h8;              wes[0] = 1'b1;
      addrs[1] = BASE_ADDR + 32'h4000; wes[1] = 1'b0;
      addrs[2] = 32'h3FFC;           wes[2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) apply(1'b0, 32'h0, 1'b1, wes[i], addrs[i]);
         else       apply(1'b1, BASE_ADDR + 32'h4004, 1'b0, 1'b0, 32'h0);
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL wr_oor ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_rdd !== exp_rd) begin miscompares++; $display("FAIL wr_oor rdata c%0d: got %h want %h", i, obs_rdd, exp_rd); end
      end
      apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      vectors++; if (obs_ctl !== exp_ctl || obs_rdi !== 32'h0) begin miscompares++; $display("FAIL wr_oor instr_oor: got ctl=%b rd=%h want ctl=%b rd=0", obs_ctl, obs_rdi, exp_ctl); end
   endtask

   task automatic test_reset_mid_op();
      instr_req = 1'b1; instr_addr = 32'h40; data_req = 1'b0; data_we = 1'b0;
      #2;
      vectors++; if (instr_gnt !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL midrst grant: got gnt=%b ma=%h want gnt=1 ma=00000040", instr_gnt, mem_addr); end
      rst_n = 1'b0;
      #1;
      vectors++; if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, data_err} !== 5'b0 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL midrst outputs: got ctl=%b ma=%h want 0", {instr_gnt, data_gnt, instr_rvalid, data_rvalid, data_err}, mem_addr); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         apply(i == 2, 32'h44, i == 2, 1'b0, 32'h48);
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL midrst ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_rdi !== exp_rd || obs_ma !== exp_ma) begin miscompares++; $display("FAIL midrst data c%0d: got rd=%h ma=%h want rd=%h ma=%h", i, obs_rdi, obs_ma, exp_rd, exp_ma); end
      end
   endtask

   task automatic test_random();
      logic [31:0] ia, da;
      for (int i = 0; i < 300; i++) begin
         ia = ($urandom_range(0, 5) == 0) ? BASE_ADDR + 32'h4000 + 32'($urandom_range(0, 255) * 4)
                                          : BASE_ADDR + 32'($urandom_range(0, 4095) * 4);
         da = ($urandom_range(0, 5) == 0) ? BASE_ADDR + 32'h4000 + 32'($urandom_range(0, 255) * 4)
                                          : BASE_ADDR + 32'($urandom_range(0, 4095) * 4);
         apply($urandom_range(0, 2) != 0, ia, $urandom_range(0, 2) != 0,
               $urandom_range(0, 4) == 0, da);
         vectors++; if (obs_ctl !== exp_ctl) begin miscompares++; $display("FAIL random ctl c%0d: got %b want %b", i, obs_ctl, exp_ctl); end
         vectors++; if (obs_ma !== exp_ma) begin miscompares++; $display("FAIL random mem_addr c%0d: got %h want %h", i, obs_ma, exp_ma); end
         vectors++; if (obs_rdi !== exp_rd || obs_rdd !== exp_rd) begin miscompares++; $display("FAIL random rdata c%0d: got %h/%h want %h", i, obs_rdi, obs_rdd, exp_rd); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fair_alternation();
      test_single_stream();
      test_write_and_oor();
      test_reset_mid_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
